// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared state type, opcodes and widths for the SPI flash reader.
package spi_flash_pkg;

  localparam int ADDR_W = 24;
  localparam int WORD_W = 32;

  localparam logic [7:0] CMD_READ       = 8'h03;
  localparam logic [7:0] CMD_RELEASE_PD = 8'hAB;

  typedef enum logic [3:0] {
    S_WAKE_SETUP,
    S_WAKE_CMD,
    S_WAKE_GAP,
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_DATA,
    S_HOLD,
    S_DONE,
    S_GAP
  } spi_flash_state_t;

  // Flash returns bytes in ascending address order; pack them little-endian.
  function automatic logic [WORD_W-1:0] le_word(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// spi_bit_engine: mode-0 SPI shifter, MSB first, up to 32 bits per start.
module spi_bit_engine
  import spi_flash_pkg::*;
#(
  parameter int SCK_HALF = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        nbits,
  input  logic [WORD_W-1:0] data,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic              done,
  output logic [WORD_W-1:0] rx
);

  localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic              active;
  logic [CW-1:0]     cnt;
  logic [5:0]        left;
  logic [WORD_W-1:0] tx;
  logic              half_end;

  assign half_end = active && (cnt == CW'(SCK_HALF - 1));
  // Asserted in the cycle whose edge ends the final high half.
  assign done = half_end && sck && (left == 6'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
      left   <= '0;
      tx     <= '0;
      rx     <= '0;
      sck    <= 1'b0;
      mosi   <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      left   <= nbits;
      tx     <= {data[WORD_W-2:0], 1'b0};
      mosi   <= data[WORD_W-1];
      sck    <= 1'b0;
    end else if (active) begin
      cnt <= half_end ? '0 : cnt + CW'(1);
      if (half_end && !sck) begin
        sck <= 1'b1;
        rx  <= {rx[WORD_W-2:0], miso};
      end else if (half_end) begin
        sck  <= 1'b0;
        left <= left - 6'd1;
        if (left == 6'd1) begin
          active <= 1'b0;
          mosi   <= 1'b0;
        end else begin
          mosi <= tx[WORD_W-1];
          tx   <= {tx[WORD_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: wakes the config flash, then serves 32-bit 0x03 reads
// for two requesters with round-robin arbitration.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int SCK_HALF    = 1,
  parameter int WAKE_CYCLES = 64
) (
  input  logic              CLK_CPU,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [WORD_W-1:0] rdata,
  output logic              init_done,
  output logic              busy,
  output logic              spi_ss,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  spi_flash_state_t  state;
  logic              last;
  logic              sel;
  logic              pick1;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       gap_cnt;

  logic              eng_start;
  logic [5:0]        eng_nbits;
  logic [WORD_W-1:0] eng_load;
  logic              eng_done;
  logic [WORD_W-1:0] eng_rx;

  // last == 1 means port 1 was granted most recently.
  assign pick1 = req1 && (!req0 || !last);

  always_comb begin
    eng_start = 1'b0;
    eng_nbits = 6'd32;
    eng_load  = '0;
    unique case (state)
      S_WAKE_SETUP: begin
        eng_start = 1'b1;
        eng_nbits = 6'd8;
        eng_load  = {CMD_RELEASE_PD, 24'h0};
      end
      S_SETUP: begin
        eng_start = 1'b1;
        eng_load  = {CMD_READ, addr};
      end
      // Data phase chains straight off the last command bit.
      S_CMD:   eng_start = eng_done;
      default: eng_start = 1'b0;
    endcase
  end

  spi_bit_engine #(.SCK_HALF(SCK_HALF)) u_eng (
    .clk   (CLK_CPU),
    .reset (reset),
    .start (eng_start),
    .nbits (eng_nbits),
    .data  (eng_load),
    .miso  (spi_miso),
    .sck   (spi_sck),
    .mosi  (spi_mosi),
    .done  (eng_done),
    .rx    (eng_rx)
  );

  always_ff @(posedge CLK_CPU) begin
    if (reset) begin
      state     <= S_WAKE_SETUP;
      spi_ss    <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
      init_done <= 1'b0;
      busy      <= 1'b1;
      last      <= 1'b1;
      sel       <= 1'b0;
      addr      <= '0;
      gap_cnt   <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        S_WAKE_SETUP: begin
          spi_ss <= 1'b0;
          state  <= S_WAKE_CMD;
        end
        S_WAKE_CMD:
          if (eng_done) begin
            spi_ss  <= 1'b1;
            gap_cnt <= '0;
            state   <= S_WAKE_GAP;
          end
        S_WAKE_GAP:
          if (gap_cnt == 16'(WAKE_CYCLES)) begin
            init_done <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        S_IDLE:
          if (req0 || req1) begin
            gnt0  <= !pick1;
            gnt1  <= pick1;
            sel   <= pick1;
            last  <= pick1;
            addr  <= pick1 ? addr1 : addr0;
            busy  <= 1'b1;
            state <= S_SETUP;
          end
        S_SETUP: begin
          spi_ss <= 1'b0;
          state  <= S_CMD;
        end
        S_CMD:
          if (eng_done) state <= S_DATA;
        S_DATA:
          if (eng_done) state <= S_HOLD;
        S_HOLD: begin
          spi_ss <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done0   <= !sel;
          done1   <= sel;
          rdata   <= le_word(eng_rx);
          busy    <= 1'b0;
          gap_cnt <= '0;
          state   <= S_GAP;
        end
        S_GAP:
          if (gap_cnt == 16'd1) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 16'd1;
        default: state <= S_WAKE_SETUP;
      endcase
    end
  end

endmodule
